// File: rtl/parking_pkg.sv
// Shared types, default widths and saturating arithmetic for the parking timer.
// Pure declarations only: no logic, no latency, no backpressure.
package parking_pkg;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_TIME_W    = 16;
  localparam int DEF_RATE      = 2;
  localparam int DEF_FEE_W     = 20;

  typedef enum logic {IDLE, HOLD} fee_state_t;

  // Product of a and b, clamped to the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_mul(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] prod;
    logic [63:0] lim;
    prod = {32'd0, a} * {32'd0, b};
    lim  = (64'd1 << w) - 64'd1;
    return (prod > lim) ? lim[31:0] : prod[31:0];
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector on the same-domain divided clock; tick is combinational from the
// current sample and the registered previous sample. No backpressure.
module tick_edge_detect (
  input  logic clk_in,
  input  logic RST,
  input  logic tick_src,
  output logic tick
);

  logic r_tick_src_q;

  always_ff @(posedge clk_in) begin
    if (RST) r_tick_src_q <= 1'b0;
    else     r_tick_src_q <= tick_src;
  end

  assign tick = tick_src & ~r_tick_src_q;

endmodule

// File: rtl/parking_timer.sv
// Per-slot elapsed-time tracking with a one-deep fee record (1-cycle exit-to-fee latency);
// exits stall while an unaccepted record is held. PARKING_MIN_FEE_EN bills at least one unit.
module parking_timer
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int TIME_W    = DEF_TIME_W,
  parameter int RATE      = DEF_RATE,
  parameter int FEE_W     = DEF_FEE_W,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk_in,
  input  logic                 RST,
  input  logic                 tick_src,
  input  logic                 enter_valid,
  input  logic [SLOT_W-1:0]    enter_slot,
  input  logic                 exit_valid,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 exit_ready,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 fee_valid,
  input  logic                 fee_ready,
  output logic [FEE_W-1:0]     fee_data,
  output logic [SLOT_W-1:0]    fee_slot,
  output logic                 err
);

  logic                 w_tick;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [TIME_W-1:0]    r_cnt [NUM_SLOTS];
  fee_state_t           r_state;
  fee_state_t           w_state_nxt;
  logic [FEE_W-1:0]     r_fee_data;
  logic [SLOT_W-1:0]    r_fee_slot;
  logic                 r_err;
  logic                 w_exit_acc;
  logic                 w_exit_legal;
  logic                 w_exit_bad;
  logic                 w_enter_ok;
  logic                 w_enter_bad;
  logic [TIME_W-1:0]    w_units;
  logic [FEE_W-1:0]     w_fee;

  tick_edge_detect u_tick_edge_detect (
    .clk_in   (clk_in),
    .RST      (RST),
    .tick_src (tick_src),
    .tick     (w_tick)
  );

  assign fee_valid    = (r_state == HOLD);
  assign exit_ready   = ~fee_valid | fee_ready;
  assign w_exit_acc   = exit_valid & exit_ready;
  assign w_exit_legal = w_exit_acc & r_occ[exit_slot];
  assign w_exit_bad   = w_exit_acc & ~r_occ[exit_slot];
  // Occupancy is judged at the start of the cycle, so a same-slot exit does not free it for this enter.
  assign w_enter_ok   = enter_valid & ~r_occ[enter_slot];
  assign w_enter_bad  = enter_valid & r_occ[enter_slot];

  always_comb begin
    w_units = r_cnt[exit_slot];
`ifdef PARKING_MIN_FEE_EN
    if (w_units == '0) w_units = TIME_W'(1);
`endif
  end

  assign w_fee = FEE_W'(sat_mul(32'(w_units), 32'(RATE), FEE_W));

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_occ      <= '0;
      r_fee_data <= '0;
      r_fee_slot <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_cnt[i] <= '0;
    end else begin
      r_err <= w_enter_bad | w_exit_bad;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_enter_ok && (enter_slot == SLOT_W'(i))) begin
          r_occ[i] <= 1'b1;
          r_cnt[i] <= '0;
        end else begin
          if (w_exit_legal && (exit_slot == SLOT_W'(i))) r_occ[i] <= 1'b0;
          if (w_tick && r_occ[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + TIME_W'(1);
        end
      end
      if (w_exit_legal) begin
        r_fee_data <= w_fee;
        r_fee_slot <= exit_slot;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_exit_legal) w_state_nxt = HOLD;
      HOLD:    if (fee_ready && !w_exit_legal) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign occupied = r_occ;
  assign fee_data = r_fee_data;
  assign fee_slot = r_fee_slot;
  assign err      = r_err;

endmodule

// File: tb/tb_parking_timer.sv
// Randomized and directed bench for parking_timer with an elapsed-time reference model
// and a fee-record scoreboard drained by an independent monitor.
module tb_parking_timer;

  localparam int NS = 4;
  localparam int TW = 8;
  localparam int FW = 12;
  localparam int RT = 2;
  localparam int MAX_EL  = (1 << TW) - 1;
  localparam int MAX_FEE = (1 << FW) - 1;

  logic          clk_in = 1'b0;
  logic          RST;
  logic          tick_src;
  logic          enter_valid;
  logic [1:0]    enter_slot;
  logic          exit_valid;
  logic [1:0]    exit_slot;
  logic          exit_ready;
  logic [NS-1:0] occupied;
  logic          fee_valid;
  logic          fee_ready;
  logic [FW-1:0] fee_data;
  logic [1:0]    fee_slot;
  logic          err;

  parking_timer #(.NUM_SLOTS(NS), .TIME_W(TW), .RATE(RT), .FEE_W(FW)) dut (
    .clk_in      (clk_in),
    .RST         (RST),
    .tick_src    (tick_src),
    .enter_valid (enter_valid),
    .enter_slot  (enter_slot),
    .exit_valid  (exit_valid),
    .exit_slot   (exit_slot),
    .exit_ready  (exit_ready),
    .occupied    (occupied),
    .fee_valid   (fee_valid),
    .fee_ready   (fee_ready),
    .fee_data    (fee_data),
    .fee_slot    (fee_slot),
    .err         (err)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int slot;
    int fee;
  } rec_t;
  rec_t exp_q[$];

  // Reference model: occupancy flags, units elapsed since entry, pending-record flag.
  bit m_occ [NS];
  int m_el  [NS];
  bit m_pend;
  bit m_err;
  bit m_prev_src;
  bit m_last_acc;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int exp_fee(input int el);
    int u;
    u = el;
`ifdef PARKING_MIN_FEE_EN
    if (u < 1) u = 1;
`endif
    return (u * RT > MAX_FEE) ? MAX_FEE : u * RT;
  endfunction

  function automatic logic [NS-1:0] occ_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic model_update();
    bit tk, rdy, acc, legal, ent_ok;
    int xs, es;
    if (RST) begin
      for (int i = 0; i < NS; i++) begin
        m_occ[i] = 1'b0;
        m_el[i]  = 0;
      end
      m_pend = 0; m_err = 0; m_prev_src = 0; m_last_acc = 1;
      exp_q.delete();
      return;
    end
    xs = int'(exit_slot);
    es = int'(enter_slot);
    tk = tick_src && !m_prev_src;
    m_prev_src = tick_src;
    rdy    = !m_pend || fee_ready;
    acc    = exit_valid && rdy;
    legal  = acc && m_occ[xs];
    ent_ok = enter_valid && !m_occ[es];
    m_err  = (enter_valid && m_occ[es]) || (acc && !m_occ[xs]);
    m_last_acc = acc;
    if (legal) exp_q.push_back('{xs, exp_fee(m_el[xs])});
    m_pend = legal || (m_pend && !fee_ready);
    for (int i = 0; i < NS; i++)
      if (m_occ[i] && tk && m_el[i] < MAX_EL) m_el[i]++;
    if (legal) m_occ[xs] = 1'b0;
    if (ent_ok) begin
      m_occ[es] = 1'b1;
      m_el[es]  = 0;
    end
  endtask

  // One clock: compare visible state mid-cycle, then advance the model past the edge.
  task automatic step();
    @(negedge clk_in);
    chk("occupied", longint'(occupied), longint'(occ_vec()));
    chk("err", longint'(err), longint'(m_err));
    chk("fee_valid", longint'(fee_valid), longint'(m_pend));
    chk("exit_ready", longint'(exit_ready), longint'(!m_pend || fee_ready));
    @(posedge clk_in);
    #1;
    model_update();
  endtask

  task automatic do_enter(input int s);
    enter_valid = 1'b1; enter_slot = 2'(s);
    step();
    enter_valid = 1'b0;
  endtask

  task automatic do_exit(input int s);
    exit_valid = 1'b1; exit_slot = 2'(s);
    step();
    exit_valid = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      tick_src = 1'b1; step();
      tick_src = 1'b0; step();
    end
  endtask

  initial begin : monitor
    logic          hold;
    logic [FW-1:0] hd;
    logic [1:0]    hs;
    rec_t          r;
    hold = 1'b0;
    forever begin
      @(negedge clk_in);
      if (hold && fee_valid === 1'b1) begin
        chk("stable_fee_data", longint'(fee_data), longint'(hd));
        chk("stable_fee_slot", longint'(fee_slot), longint'(hs));
      end
      hold = 1'b0;
      if (fee_valid === 1'b1 && fee_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_fee_record", longint'(exp_q.size()), 1);
        else begin
          r = exp_q.pop_front();
          chk("sb_fee_data", longint'(fee_data), longint'(r.fee));
          chk("sb_fee_slot", longint'(fee_slot), longint'(r.slot));
        end
      end else if (fee_valid === 1'b1 && RST === 1'b0) begin
        hold = 1'b1; hd = fee_data; hs = fee_slot;
      end
    end
  end

  initial begin : stim
    int min_fee;
`ifdef PARKING_MIN_FEE_EN
    min_fee = RT;
`else
    min_fee = 0;
`endif
    RST = 1'b1; tick_src = 1'b0; enter_valid = 1'b0; enter_slot = '0;
    exit_valid = 1'b0; exit_slot = '0; fee_ready = 1'b1;
    @(posedge clk_in); #1; model_update();
    step();
    RST = 1'b0;
    chk("rst_fee_data", longint'(fee_data), 0);
    chk("rst_fee_slot", longint'(fee_slot), 0);
    chk("rst_occupied", longint'(occupied), 0);
    chk("rst_exit_ready", longint'(exit_ready), 1);

    // Five units on slot 1.
    do_enter(1); do_ticks(5); do_exit(1);
    chk("s1_fee_valid", longint'(fee_valid), 1);
    chk("s1_fee_data", longint'(fee_data), 10);
    chk("s1_fee_slot", longint'(fee_slot), 1);
    chk("s1_occ", longint'(occupied[1]), 0);
    step();

    // Exit before any tick.
    do_enter(2); do_exit(2);
    chk("s2_fee_data", longint'(fee_data), longint'(min_fee));
    step();

    // Counter saturation.
    do_enter(0); do_ticks(300); do_exit(0);
    chk("s3_fee_data", longint'(fee_data), 510);
    step();

    // Backpressure: record for slot 3 held, slot 0 exit waits.
    do_enter(3); do_enter(0); do_ticks(2);
    fee_ready = 1'b0;
    do_exit(3);
    chk("s4_fee_slot", longint'(fee_slot), 3);
    exit_valid = 1'b1; exit_slot = 2'd0;
    repeat (3) begin
      step();
      chk("s4_exit_ready", longint'(exit_ready), 0);
      chk("s4_hold_slot", longint'(fee_slot), 3);
      chk("s4_hold_data", longint'(fee_data), 4);
    end
    fee_ready = 1'b1;
    step();
    exit_valid = 1'b0;
    chk("s4_new_slot", longint'(fee_slot), 0);
    chk("s4_new_data", longint'(fee_data), 4);
    chk("s4_new_valid", longint'(fee_valid), 1);
    step();

    // Illegal requests.
    do_enter(1);
    chk("s5_err0", longint'(err), 0);
    do_enter(1);
    chk("s5_err1", longint'(err), 1);
    step();
    chk("s5_err_clr", longint'(err), 0);
    do_exit(2);
    chk("s5_err2", longint'(err), 1);
    chk("s5_no_fee", longint'(fee_valid), 0);
    chk("s5_occ", longint'(occupied), 4'b0010);
    step();

    // Entry beats a same-cycle tick; reset mid-HOLD.
    do_exit(1); step();
    enter_valid = 1'b1; enter_slot = 2'd1; tick_src = 1'b1;
    step();
    enter_valid = 1'b0; tick_src = 1'b0; fee_ready = 1'b0;
    do_exit(1);
    chk("s6_fee_data", longint'(fee_data), longint'(min_fee));
    do_enter(2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("s6_rst_occ", longint'(occupied), 0);
    chk("s6_rst_valid", longint'(fee_valid), 0);
    chk("s6_rst_ready", longint'(exit_ready), 1);
    fee_ready = 1'b1;
    step();

    // Randomized traffic; an unaccepted exit request is held by the requester.
    for (int c = 0; c < 3000; c++) begin
      tick_src    = 1'($urandom_range(0, 1));
      enter_valid = ($urandom_range(0, 3) == 0);
      enter_slot  = 2'($urandom_range(0, 3));
      if (!(exit_valid && !m_last_acc)) begin
        exit_valid = ($urandom_range(0, 2) == 0);
        exit_slot  = 2'($urandom_range(0, 3));
      end
      fee_ready = ($urandom_range(0, 2) != 0);
      RST       = ($urandom_range(0, 199) == 0);
      step();
    end

    RST = 1'b0; tick_src = 1'b0; enter_valid = 1'b0; exit_valid = 1'b0; fee_ready = 1'b1;
    repeat (4) step();
    chk("queue_drained", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/parking_timer.md
# parking_timer

Per-slot parking duration timer and fee generator, directly downstream of the system clock divider. It consumes the divider's slow square wave as a time base: each rising edge of that wave is one billing unit. It tracks occupancy and elapsed units for every slot, and on a car exit emits one fee record through a valid/ready handshake to the display/billing logic.

## Interface
- NUM_SLOTS, 4, number of parking slots (≥2); SLOT_W = $clog2(NUM_SLOTS)
- TIME_W, 16, elapsed-unit counter width per slot
- RATE, 2, fee units charged per elapsed time unit
- FEE_W, 20, fee width
- clk_in  in  1  system clock; single clock domain
- RST  in  1  reset, synchronous, active-high
- tick_src  in  1  divided clock from the clock divider (register output, same domain); rising edge = one time unit
- enter_valid  in  1  car-entry strobe, single cycle, always accepted
- enter_slot  in  SLOT_W  slot being entered
- exit_valid  in  1  car-exit request
- exit_slot  in  SLOT_W  slot being vacated
- exit_ready  out  1  exit can be accepted this cycle
- occupied  out  NUM_SLOTS  per-slot occupancy
- fee_valid  out  1  fee record pending
- fee_ready  in  1  consumer accepts fee record
- fee_data  out  FEE_W  fee amount
- fee_slot  out  SLOT_W  slot the fee belongs to
- err  out  1  one-cycle pulse on an illegal request

## Operation
- Tick detect: tick = tick_src & ~tick_src_q, where tick_src_q is tick_src registered. No synchronizer is needed because tick_src is in the same domain.
- On tick, every occupied slot counter increments and saturates at 2^TIME_W−1. Unoccupied counters hold.
- Entry, enter_valid with the slot free: set occupied, clear the counter to 0. Entry wins over a same-cycle tick.
- Entry with the slot already occupied (as sampled at the start of the cycle): ignored, err=1 for one cycle.
- exit_ready = ~fee_valid | fee_ready.
- An exit is accepted when exit_valid & exit_ready.
- Accepted exit on an occupied slot:
  - fee_data = counter × RATE, using the pre-tick counter value and saturating at 2^FEE_W−1.
  - fee_slot = exit_slot, fee_valid set, occupied cleared.
- Accepted exit on a free slot: no fee, err=1 for one cycle.
- An exit_valid with exit_ready low is not consumed. The requester holds it, and it is not an error.
- Output FSM:
  - IDLE → HOLD on a legal accepted exit.
  - HOLD → IDLE on fee_ready when no new legal exit is accepted in the same cycle.
  - HOLD → HOLD (record reloaded) on fee_ready together with a legal exit.
- Enter and exit on the same slot in the same cycle: the exit is processed; the enter sees the slot occupied and raises err.
- Enter and exit on different slots in the same cycle: both are processed.

## Timing
- Reset values:
  - occupied=0, all counters=0, fee_valid=0, fee_data=0, fee_slot=0, err=0, tick_src_q=0, FSM=IDLE.
  - exit_ready=1, because fee_valid=0.
- RST mid-operation drops any pending fee and vacates all slots on the next edge.
- Tick latency: a tick_src rising edge sampled at cycle N updates the counters at N+1.
- Exit latency: an exit accepted at cycle N gives fee_valid=1 and occupied[slot]=0 at N+1.
- Enter latency: an enter at N gives occupied=1 and counter=0 at N+1.
- Fee record: fee_data and fee_slot are stable while fee_valid is high and fee_ready is low. Transfer occurs on fee_valid & fee_ready.
- err is registered and asserts at N+1 for a request at N.

## Configuration
- PARKING_MIN_FEE_EN defined: billed units = max(counter, 1). Every legal exit costs at least RATE.
- PARKING_MIN_FEE_EN undefined: billed units = counter. An exit before the first tick gives fee_data=0.

## Structure
- Package parking_pkg:
  - fee FSM enum fee_state_t {IDLE, HOLD}
  - helper function for saturating multiply
  - default widths as localparams
- Sub-module tick_edge_detect (clk_in, RST, tick_src → tick) holds the edge register.
- Counters are a NUM_SLOTS×TIME_W register array in the top module.

## Test plan
Bench parameters: NUM_SLOTS=4, TIME_W=8, FEE_W=12, RATE=2.
- Enter slot 1, 5 tick_src rising edges, exit slot 1 with fee_ready=1 → fee_valid one cycle later, fee_data=10, fee_slot=1, occupied[1]=0.
- Enter slot 2, exit slot 2 before any tick:
  - with PARKING_MIN_FEE_EN → fee_data=2
  - without → fee_data=0
- Enter slot 0, 300 ticks, exit → counter saturates at 255, fee_data=510.
- Hold fee_ready=0 after exit of slot 3, then request exit of slot 0 → exit_ready=0, fee record stable. Raise fee_ready → slot 0 exit accepted in the same cycle, fee_slot=0 next cycle.
- Enter slot 1 twice; exit free slot 2 → err pulses twice, occupancy unchanged, no fee_valid.
- Enter slot 1 on the same cycle as a tick, then assert RST mid-HOLD → counter 0 after the enter; after reset, occupied=0, fee_valid=0, exit_ready=1.
